// File: rtl/read_buffer.sv
// read_buffer: holds one 512-bit line from ReadMaster and streams it to the
// MAC pipeline as 1, 4, 8 or 16 low-aligned beats, chosen by ConvSize_i.
// The beat width is captured when the line is accepted. A new line can be
// taken on the same edge that the final beat leaves, so lines follow each
// other with no bubble.
module read_buffer (
  input  logic         clk,
  input  logic         rstn,
  input  logic [511:0] ReadData_i,
  input  logic         ReadValid_i,
  input  logic         ReadFirst_i,
  input  logic         ReadLast_i,
  output logic         ReadReady_o,
  input  logic [2:0]   ConvSize_i,
  output logic [511:0] Data_o,
  output logic         Valid_o,
  input  logic         Halt_i,
  output logic         First_o,
  output logic         Last_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Beat modes: 0 = 1 x 512, 1 = 4 x 128, 2 = 8 x 64, 3 = 16 x 32
  function automatic logic [1:0] size_mode(input logic [2:0] size);
    logic [1:0] mode;
    case (size)
      3'd0, 3'd1: mode = 2'd0;
      3'd2, 3'd3: mode = 2'd1;
      3'd4:       mode = 2'd2;
      default:    mode = 2'd3;
    endcase
    return mode;
  endfunction

  // Index of the final beat for a given mode
  function automatic logic [3:0] final_idx(input logic [1:0] mode);
    logic [3:0] idx;
    case (mode)
      2'd0:    idx = 4'd0;
      2'd1:    idx = 4'd3;
      2'd2:    idx = 4'd7;
      default: idx = 4'd15;
    endcase
    return idx;
  endfunction

  state_t         state_r, state_s;
  logic [511:0]   line_r;
  logic           first_r, last_r;
  logic [3:0]     cnt_r, cnt_s;
  logic [1:0]     mode_r;
  logic           valid_s, advance_s, final_s, ready_s, accept_s;
  logic [511:0]   data_s;

  // Handshake and beat-advance qualifiers
  always_comb begin
    valid_s   = (state_r == DRAIN);
    final_s   = (cnt_r == final_idx(mode_r));
    advance_s = valid_s & ~Halt_i;
    ready_s   = ~valid_s | (final_s & advance_s);
    accept_s  = ReadValid_i & ready_s;
  end

  // Next state and next beat counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (accept_s) begin
      state_s = DRAIN;
      cnt_s   = 4'd0;
    end else if (advance_s && final_s) begin
      state_s = EMPTY;
      cnt_s   = 4'd0;
    end else if (advance_s) begin
      cnt_s   = cnt_r + 4'd1;
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  // State, counter and captured line registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= EMPTY;
      cnt_r   <= 4'd0;
      line_r  <= 512'd0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      mode_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        line_r  <= ReadData_i;
        first_r <= ReadFirst_i;
        last_r  <= ReadLast_i;
        mode_r  <= size_mode(ConvSize_i);
      end else begin
        line_r  <= line_r;
        first_r <= first_r;
        last_r  <= last_r;
        mode_r  <= mode_r;
      end
    end
  end

  // Select the current beat slice, zero-extended, and blank it when idle
  always_comb begin
    data_s = 512'd0;
    case (mode_r)
      2'd0:    data_s = line_r;
      2'd1:    data_s = {384'd0, line_r[{cnt_r[1:0], 7'd0} +: 128]};
      2'd2:    data_s = {448'd0, line_r[{cnt_r[2:0], 6'd0} +: 64]};
      default: data_s = {480'd0, line_r[{cnt_r, 5'd0} +: 32]};
    endcase
    if (!valid_s) begin
      data_s = 512'd0;
    end else begin
      data_s = data_s;
    end
  end

  assign ReadReady_o = ready_s;
  assign Valid_o     = valid_s;
  assign Data_o      = data_s;
  assign First_o     = valid_s & first_r & (cnt_r == 4'd0);
  assign Last_o      = valid_s & last_r & final_s;

endmodule

// File: tb/tb_read_buffer.sv
// Randomized bench for read_buffer. The reference model expands each accepted
// line into its list of expected beats and keeps them in a queue. The block
// must show the head of that queue, the queue drains by one entry per
// unhalted cycle, and a new line is expected to be taken whenever the queue
// is empty or its last beat is leaving.
module tb_read_buffer;

  logic         clk;
  logic         rstn;
  logic [511:0] ReadData_i;
  logic         ReadValid_i;
  logic         ReadFirst_i;
  logic         ReadLast_i;
  logic         ReadReady_o;
  logic [2:0]   ConvSize_i;
  logic [511:0] Data_o;
  logic         Valid_o;
  logic         Halt_i;
  logic         First_o;
  logic         Last_o;

  read_buffer dut (
    .clk         (clk),
    .rstn        (rstn),
    .ReadData_i  (ReadData_i),
    .ReadValid_i (ReadValid_i),
    .ReadFirst_i (ReadFirst_i),
    .ReadLast_i  (ReadLast_i),
    .ReadReady_o (ReadReady_o),
    .ConvSize_i  (ConvSize_i),
    .Data_o      (Data_o),
    .Valid_o     (Valid_o),
    .Halt_i      (Halt_i),
    .First_o     (First_o),
    .Last_o      (Last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } beat_t;

  beat_t beat_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int beat_width(input logic [2:0] size);
    if (size >= 3'd5)      return 32;
    else if (size == 3'd4) return 64;
    else if (size >= 3'd2) return 128;
    else                   return 512;
  endfunction

  // Split one accepted line into its expected beats and queue them
  task automatic push_line(input logic [511:0] d, input logic f, input logic l, input logic [2:0] size);
    int w, n;
    logic [511:0] mask, tmp;
    beat_t b;
    w = beat_width(size);
    n = 512 / w;
    mask = (w == 512) ? {512{1'b1}} : ((512'd1 << w) - 512'd1);
    for (int k = 0; k < n; k++) begin
      tmp = (d >> (k * w)) & mask;
      b.d = tmp;
      b.f = f && (k == 0);
      b.l = l && (k == n - 1);
      beat_q.push_back(b);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, {511'd0, Valid_o},     512'd0);
    check_eq({tag, "_ready"}, {511'd0, ReadReady_o}, 512'd1);
    check_eq({tag, "_data"},  Data_o,                512'd0);
    check_eq({tag, "_first"}, {511'd0, First_o},     512'd0);
    check_eq({tag, "_last"},  {511'd0, Last_o},      512'd0);
  endtask

  logic pending;
  logic exp_valid, exp_ready, accept_m;
  logic [511:0] rnd;

  initial begin
    rstn        = 1'b0;
    ReadData_i  = 512'd0;
    ReadValid_i = 1'b0;
    ReadFirst_i = 1'b0;
    ReadLast_i  = 1'b0;
    ConvSize_i  = 3'd7;
    Halt_i      = 1'b0;
    pending     = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);

      // Occasional asynchronous reset pulse, very likely mid-line
      if (cyc % 700 == 350) begin
        rstn = 1'b0;
        #1;
        check_idle("midreset");
        beat_q.delete();
        pending     = 1'b0;
        ReadValid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("inreset");
        rstn = 1'b1;
      end

      // ReadMaster: hold the offered line until it is taken
      if (!pending) begin
        if (cyc < 1000) ReadValid_i = 1'b1;
        else            ReadValid_i = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
        ReadData_i  = rnd;
        ReadFirst_i = $urandom_range(0, 1);
        ReadLast_i  = $urandom_range(0, 1);
        pending     = ReadValid_i;
      end
      if ($urandom_range(0, 7) == 0) ConvSize_i = $urandom_range(0, 7);
      Halt_i = (cyc < 500) ? 1'b0 : ($urandom_range(0, 3) == 0);

      #1;
      exp_valid = (beat_q.size() > 0);
      exp_ready = (beat_q.size() == 0) || (beat_q.size() == 1 && !Halt_i);
      accept_m  = ReadValid_i && exp_ready;
      check_eq("ready", {511'd0, ReadReady_o}, {511'd0, exp_ready});
      check_eq("valid", {511'd0, Valid_o},     {511'd0, exp_valid});
      if (exp_valid) begin
        check_eq("data",  Data_o,               beat_q[0].d);
        check_eq("first", {511'd0, First_o},    {511'd0, beat_q[0].f});
        check_eq("last",  {511'd0, Last_o},     {511'd0, beat_q[0].l});
      end else begin
        check_eq("data_idle",  Data_o,            512'd0);
        check_eq("first_idle", {511'd0, First_o}, 512'd0);
        check_eq("last_idle",  {511'd0, Last_o},  512'd0);
      end

      @(posedge clk);
      if (exp_valid && !Halt_i) void'(beat_q.pop_front());
      if (accept_m) begin
        push_line(ReadData_i, ReadFirst_i, ReadLast_i, ConvSize_i);
        pending = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
